// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter with a built-in golden "101" matcher.
//
// Accepts a pattern word, bit length and repeat count over a valid/ready handshake,
// then shifts the pattern out MSB-first, one bit per clock. Optional idle gaps are
// inserted between repeats. A golden overlapping "101" matcher watches every bit
// driven on data_out and raises exp_detect aligned to a Moore detector's output.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous, active-high reset
//   pat_valid   pattern request valid
//   pat_ready   high in IDLE only; request accepted on pat_valid && pat_ready
//   pat_data    pattern word; bit pat_len-1 is transmitted first
//   pat_len     number of bits to send (values above MAX_LEN are clamped)
//   pat_repeat  number of transmissions (0 is treated as 1)
//   data_out    registered serial bit to the detector
//   data_valid  high when data_out carries a pattern bit
//   exp_detect  golden "101" detect, registered
//   busy        high while shifting or in a gap
//   done        one-cycle pulse after the last bit of the last repeat
module seq_pattern_gen #(
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned LEN_W      = 5,
    parameter int unsigned REP_W      = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic        IDLE_BIT   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pat_valid,
    output logic               pat_ready,
    input  logic [MAX_LEN-1:0] pat_data,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic [REP_W-1:0]   pat_repeat,
    output logic               data_out,
    output logic               data_valid,
    output logic               exp_detect,
    output logic               busy,
    output logic               done
);

    localparam int unsigned IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GapLoad = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap,
        StFin
    } state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IdxW-1:0]    bit_idx_q, bit_idx_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic               data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    // Last two bits seen; together with data_out_q they form the 3-bit history window.
    logic [1:0]         hist_q, hist_d;
    logic               exp_detect_q, exp_detect_d;

    logic [LEN_W-1:0]   len_clamp;
    logic [LEN_W-1:0]   len_clamp_m1;
    logic [LEN_W-1:0]   len_m1;
    logic [REP_W-1:0]   rep_load;

    assign len_clamp    = (pat_len > MaxLen) ? MaxLen : pat_len;
    assign len_clamp_m1 = len_clamp - LEN_W'(1);
    assign len_m1       = len_q - LEN_W'(1);
    assign rep_load     = (pat_repeat == '0) ? '0 : pat_repeat - REP_W'(1);

    // Next-state logic for the transfer FSM and its datapath.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        bit_idx_d = bit_idx_q;
        rep_d     = rep_q;
        gap_d     = gap_q;

        unique case (state_q)
            StIdle: begin
                if (pat_valid) begin
                    pat_d     = pat_data;
                    len_d     = len_clamp;
                    bit_idx_d = IdxW'(len_clamp_m1);
                    rep_d     = rep_load;
                    state_d   = (len_clamp == '0) ? StFin : StShift;
                end
            end
            StShift: begin
                if (bit_idx_q == '0) begin
                    if (rep_q == '0) begin
                        state_d = StFin;
                    end else begin
                        rep_d     = rep_q - REP_W'(1);
                        bit_idx_d = IdxW'(len_m1);
                        if (GAP_CYCLES > 0) begin
                            state_d = StGap;
                            gap_d   = GapW'(GapLoad);
                        end
                    end
                end else begin
                    bit_idx_d = bit_idx_q - IdxW'(1);
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StShift;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // data_out/data_valid are registered: look ahead at the next state so the first
    // bit appears right after the accepting edge.
    always_comb begin
        data_out_d   = IDLE_BIT;
        data_valid_d = 1'b0;
        if (state_d == StShift) begin
            data_out_d   = pat_d[bit_idx_d];
            data_valid_d = 1'b1;
        end
    end

    // Golden matcher: history shifts on every edge, idle and gap bits included.
    always_comb begin
        hist_d       = {hist_q[0], data_out_q};
        exp_detect_d = ({hist_q, data_out_q} == 3'b101);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pat_q        <= '0;
            len_q        <= '0;
            bit_idx_q    <= '0;
            rep_q        <= '0;
            gap_q        <= '0;
            data_out_q   <= IDLE_BIT;
            data_valid_q <= 1'b0;
            hist_q       <= '0;
            exp_detect_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            bit_idx_q    <= bit_idx_d;
            rep_q        <= rep_d;
            gap_q        <= gap_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            hist_q       <= hist_d;
            exp_detect_q <= exp_detect_d;
        end
    end

    assign pat_ready  = (state_q == StIdle);
    assign busy       = (state_q == StShift) || (state_q == StGap);
    assign done       = (state_q == StFin);
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign exp_detect = exp_detect_q;

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial bit-stream transmitter that drives the single-bit data input of the sequence detector. It accepts a pattern word, a bit length and a repeat count over a valid/ready handshake, then shifts the pattern out MSB-first, one bit per clock, with optional idle gaps between repeats. It also runs an internal golden "101" overlapping matcher on everything it drives and produces exp_detect, aligned to the detector's Moore output, so benches can compare cycle-by-cycle.

Parameters:
MAX_LEN, 16, maximum pattern length in bits.
LEN_W, 5, width of pat_len; must hold MAX_LEN.
REP_W, 4, width of pat_repeat.
GAP_CYCLES, 2, idle-bit cycles inserted between consecutive repeats (0 = back-to-back).
IDLE_BIT, 1'b0, value driven on data_out when not shifting.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
pat_valid  in  1  pattern request valid.
pat_ready  out  1  block can accept a pattern.
pat_data  in  MAX_LEN  pattern; bit pat_len-1 is sent first.
pat_len  in  LEN_W  number of bits to send, 0..MAX_LEN.
pat_repeat  in  REP_W  number of transmissions; 0 is treated as 1.
data_out  out  1  serial bit to the detector's data input.
data_valid  out  1  high when data_out carries a pattern bit, not an idle or gap bit.
exp_detect  out  1  golden "101" detect, cycle-aligned to the detector output.
busy  out  1  transfer in progress.
done  out  1  one-cycle pulse after the last bit of the last repeat.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, data_out=IDLE_BIT, data_valid=0, exp_detect=0, busy=0, done=0, pat_ready=1.
  - History register cleared to 0.
  - Reset mid-transfer aborts immediately; no done pulse is generated.
- pat_ready=1 only in IDLE and combinational from state. A transfer is accepted when pat_valid && pat_ready at a clk edge.
- At acceptance, capture pat_data, pat_len clamped to MAX_LEN, and pat_repeat (0 becomes 1).
  - bit_idx = len-1, rep_cnt = repeats-1.
- FSM states:
  - IDLE: wait for acceptance. If the captured len=0, go to FIN; otherwise go to SHIFT.
  - SHIFT: data_out=pat[bit_idx], data_valid=1, busy=1, bit_idx decrements each cycle.
    - On bit_idx=0 with rep_cnt=0, go to FIN.
    - On bit_idx=0 with rep_cnt>0, decrement rep_cnt and reload bit_idx=len-1.
      - If GAP_CYCLES>0, go to GAP.
      - Otherwise stay in SHIFT, with no bubble between repeats.
  - GAP: data_out=IDLE_BIT, data_valid=0, busy=1 for exactly GAP_CYCLES cycles, then return to SHIFT.
  - FIN: one cycle with done=1, busy=0, data_out=IDLE_BIT, then go to IDLE.
- Latency:
  - Acceptance at edge k puts the first bit on data_out after edge k, so data_out is registered.
  - The last bit is held for one cycle; done is high in the following cycle.
  - pat_ready returns the cycle after done.
- Total cycles from acceptance to done = len*repeats + GAP_CYCLES*(repeats-1) + 1.
- Golden matcher: a 3-bit history h shifts in data_out on every clock edge, including idle and gap bits.
  - exp_detect is registered: it equals 1 in the cycle after the edge that captured h=3'b101.
  - Overlap is allowed: "10101" yields two detects.
  - The history is not cleared between transfers, only by rst, matching a detector that runs continuously.
- pat_valid while busy is ignored; pat_data, pat_len and pat_repeat changes after acceptance have no effect.
- No X on any output after the first reset edge.

Test Plan:
- Reset then idle: rst high for 2 cycles → all outputs at reset values, pat_ready=1, exp_detect stays 0 for 10 idle cycles.
- Basic transfer: pat_data=16'h0005, pat_len=3, pat_repeat=1 → data_out 1,0,1 with data_valid=1 for 3 cycles, exp_detect=1 exactly once (cycle after the third bit), done pulse at acceptance+4.
- Overlap and repeat, GAP_CYCLES=0: pat=4'b1010, len=4, repeat=2 → stream 10101010 with no bubble, exp_detect pulses 3 times, done at acceptance+9.
- Gap insertion, GAP_CYCLES=2: pat=3'b101, repeat=3 → 101,00,101,00,101 with data_valid low in gaps, 3 detects, done at acceptance+14.
- Boundaries:
  - len=0 → no data_valid, done the cycle after acceptance.
  - pat_repeat=0 → behaves as 1.
  - pat_len=20 → clamped to 16 bits.
  - pat_valid held high while busy → only one transfer accepted.
- Reset mid-operation: rst asserted during the 2nd bit of a len=8 transfer → next cycle is IDLE, no done pulse, history cleared. A new transfer after release works normally.
